button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 165 ++++++++++++++++
 tb/tb_button_conditioner.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Two-channel pushbutton conditioner: synchronize, debounce, and emit single-cycle
// move pulses with auto-repeat while a button is held.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 20000000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic raw_left,
    input  logic raw_right,
    output logic btn_left,
    output logic btn_right,
    output logic left_level,
    output logic right_level
);

    localparam logic [25:0] DEB_C = 26'(DEBOUNCE_CYCLES);
    localparam logic [25:0] RD_C  = 26'(REPEAT_DELAY);
    localparam logic [25:0] RP_C  = 26'(REPEAT_PERIOD);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        HELD         = 3'd2,
        REPEAT       = 3'd3,
        RELEASE_WAIT = 3'd4
    } state_t;

    // Channel 0 is left, channel 1 is right.
    logic [1:0] raw_s;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] pulse_s;
    logic [1:0] level_s;
    logic       btn_left_q;
    logic       btn_right_q;

    assign raw_s = {raw_right, raw_left};

    // Two-flop synchronizers for both raw buttons
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        state_t      state_q;
        state_t      state_d;
        logic [25:0] cnt_q;
        logic [25:0] cnt_d;
        logic        pulse_d;
        logic        level_q;
        logic        s;

        assign s = sync2_q[ch];

        // Next-state and pulse decode; the pulse fires on the edge that commits the transition
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pulse_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (s) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = 26'd1;
                    end else begin
                        cnt_d   = 26'd0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_d = IDLE;
                        cnt_d   = 26'd0;
                    end else if (cnt_q == DEB_C) begin
                        state_d = HELD;
                        cnt_d   = 26'd0;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 26'd1;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = 26'd1;
                    end else if (cnt_q + 26'd1 == RD_C) begin
                        state_d = REPEAT;
                        cnt_d   = 26'd0;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 26'd1;
                    end
                end
                REPEAT: begin
                    if (!s) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = 26'd1;
                    end else if (cnt_q + 26'd1 == RP_C) begin
                        cnt_d   = 26'd0;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 26'd1;
                    end
                end
                RELEASE_WAIT: begin
                    // A re-press during release qualification restarts repeat timing silently
                    if (s) begin
                        state_d = HELD;
                        cnt_d   = 26'd0;
                    end else if (cnt_q == DEB_C) begin
                        state_d = IDLE;
                        cnt_d   = 26'd0;
                    end else begin
                        cnt_d   = cnt_q + 26'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 26'd0;
                end
            endcase
        end

        // Channel state, counter and registered level
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= IDLE;
                cnt_q   <= 26'd0;
                level_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= (state_d == HELD) || (state_d == REPEAT) || (state_d == RELEASE_WAIT);
            end
        end

        assign pulse_s[ch] = pulse_d;
        assign level_s[ch] = level_q;
    end

    // Pulse outputs: right wins a same-cycle collision, left is dropped; enable gates both
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_left_q  <= 1'b0;
            btn_right_q <= 1'b0;
        end else begin
            btn_right_q <= pulse_s[1] & enable;
            btn_left_q  <= pulse_s[0] & ~pulse_s[1] & enable;
        end
    end

    assign btn_left    = btn_left_q;
    assign btn_right   = btn_right_q;
    assign left_level  = level_s[0];
    assign right_level = level_s[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios with fixed pulse-cycle expectations
// plus random bouncy stimulus against a run-length reference model.
module tb_button_conditioner;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic raw_left;
    logic raw_right;
    logic btn_left;
    logic btn_right;
    logic left_level;
    logic right_level;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: two-stage sample pipe, accepted level, opposite-sample run, time since hold start
    int p1 [2];
    int p2 [2];
    int lvl[2];
    int run[2];
    int tmr[2];

    int          cyc;
    logic [63:0] mask_l, mask_r, mask_ll, mask_rl;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .raw_left   (raw_left),
        .raw_right  (raw_right),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .left_level (left_level),
        .right_level(right_level)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            p1[c] = 0; p2[c] = 0; lvl[c] = 0; run[c] = 0; tmr[c] = 0;
        end
    endtask

    // A level flips after DEB+1 consecutive opposite samples; pulses at press and on the repeat schedule
    task automatic model_chan(input int c, input logic v, output logic pulse);
        int x;
        x = p2[c];
        p2[c] = p1[c];
        p1[c] = int'(v);
        pulse = 1'b0;
        if (x != lvl[c]) begin
            run[c]++;
            if (run[c] == DEB + 1) begin
                lvl[c] = x;
                run[c] = 0;
                if (lvl[c] == 1) begin
                    pulse  = 1'b1;
                    tmr[c] = 0;
                end
            end
        end else begin
            if (lvl[c] == 1) begin
                if (run[c] > 0) begin
                    tmr[c] = 0;
                end else begin
                    tmr[c]++;
                    if (tmr[c] == RD || (tmr[c] > RD && (tmr[c] - RD) % RP == 0)) pulse = 1'b1;
                end
            end
            run[c] = 0;
        end
    endtask

    task automatic do_cycle(input logic l, input logic r, input logic en, input logic rst);
        logic pl, pr, el, er;
        logic was_rst;
        @(negedge clk);
        was_rst   = reset;
        raw_left  = l;
        raw_right = r;
        enable    = en;
        reset     = rst;
        if (rst && !was_rst) begin
            #1;
            check("async_reset_btn_r", btn_right, 1'b0);
            check("async_reset_lvl_l", left_level, 1'b0);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            model_clear();
            el = 1'b0;
            er = 1'b0;
        end else begin
            model_chan(0, l, pl);
            model_chan(1, r, pr);
            er = pr & en;
            el = pl & ~pr & en;
        end
        check("btn_left", btn_left, el);
        check("btn_right", btn_right, er);
        check("left_level", left_level, (lvl[0] == 1));
        check("right_level", right_level, (lvl[1] == 1));
        if (cyc >= 0 && cyc < 64) begin
            mask_l[cyc]  = btn_left;
            mask_r[cyc]  = btn_right;
            mask_ll[cyc] = left_level;
            mask_rl[cyc] = right_level;
        end
        cyc++;
    endtask

    task automatic begin_scen();
        cyc = -100;
        do_cycle(1'b0, 1'b0, 1'b1, 1'b1);
        do_cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cyc     = 0;
        mask_l  = 64'd0;
        mask_r  = 64'd0;
        mask_ll = 64'd0;
        mask_rl = 64'd0;
    endtask

    initial begin
        logic l, r, en, rst;
        model_clear();
        cyc       = -100;
        reset     = 1'b0;
        enable    = 1'b1;
        raw_left  = 1'b0;
        raw_right = 1'b0;

        // Reset state
        begin_scen();

        // Clean press and release of right
        for (int i = 0; i < 20; i++) do_cycle(1'b0, (i <= 7), 1'b1, 1'b0);
        check64("s027_btn_r_cycles", mask_r, 64'h0000_0000_0000_0040);
        check64("s027_btn_l_cycles", mask_l, 64'h0);
        check64("s027_lvl_r_cycles", mask_rl, 64'h0000_0000_0000_3FC0);

        // Left bounce restarts qualification
        begin_scen();
        for (int i = 0; i < 25; i++) do_cycle(((i <= 2) || (i >= 4 && i <= 20)), 1'b0, 1'b1, 1'b0);
        check64("s028_btn_l_first20", {44'd0, mask_l[19:0]}, 64'h0000_0000_0000_0400);

        // Auto-repeat schedule on a long right hold
        begin_scen();
        for (int i = 0; i < 36; i++) do_cycle(1'b0, (i <= 30), 1'b1, 1'b0);
        check64("s029_btn_r_repeat", mask_r, 64'h0000_0000_8421_0040);

        // Simultaneous press: right wins, left dropped
        begin_scen();
        for (int i = 0; i < 20; i++) do_cycle((i <= 7), (i <= 7), 1'b1, 1'b0);
        check64("s030_btn_r", mask_r, 64'h0000_0000_0000_0040);
        check64("s030_btn_l", mask_l, 64'h0);
        check64("s030_lvl_l", mask_ll, 64'h0000_0000_0000_3FC0);
        check64("s030_lvl_r", mask_rl, 64'h0000_0000_0000_3FC0);

        // Reset mid-debounce discards progress
        begin_scen();
        for (int i = 0; i < 16; i++) do_cycle(1'b0, 1'b1, 1'b1, (i == 4 || i == 5));
        check64("s031_btn_r", mask_r, 64'h0000_0000_0000_1000);

        // Enable low suppresses pulses without queuing
        begin_scen();
        for (int i = 0; i < 25; i++) do_cycle((i <= 20), 1'b0, (i >= 17), 1'b0);
        check64("s032_btn_l", mask_l, 64'h0000_0000_0020_0000);
        check64("s032_lvl_l_rise", {62'd0, mask_ll[6:5]}, 64'd2);

        // Random bouncy stimulus against the model
        begin_scen();
        l = 1'b0;
        r = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) l = ~l;
            if ($urandom_range(0, 11) == 0) r = ~r;
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 299) == 0);
            do_cycle(l, r, en, rst);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
